// File: rtl/caliptra_apb_arb_pkg.sv
// caliptra_apb_arb_pkg: shared widths and FSM encoding for the APB arbiter
package caliptra_apb_arb_pkg;
   localparam int APB_AW = 32;
   localparam int APB_DW = 32;
   localparam int APB_UW = 32;
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} arb_state_e;
endpackage

// File: rtl/caliptra_apb_arbiter.sv
// caliptra_apb_arbiter: two-requester round-robin APB arbiter with access timeout
module caliptra_apb_arbiter
   import caliptra_apb_arb_pkg::*;
#(
   parameter int unsigned       TIMEOUT_CYCLES = 1024,
   parameter logic [APB_UW-1:0] PORT0_PAUSER   = 32'hFFFF_FFFF,
   parameter logic [APB_UW-1:0] PORT1_PAUSER   = 32'h0000_0001
) (
   input  logic              core_clk,
   input  logic              cptra_rst_b,
   input  logic              s0_psel,
   input  logic              s0_penable,
   input  logic              s0_pwrite,
   input  logic [APB_AW-1:0] s0_paddr,
   input  logic [APB_DW-1:0] s0_pwdata,
   output logic [APB_DW-1:0] s0_prdata,
   output logic              s0_pready,
   output logic              s0_pslverr,
   input  logic              s1_psel,
   input  logic              s1_penable,
   input  logic              s1_pwrite,
   input  logic [APB_AW-1:0] s1_paddr,
   input  logic [APB_DW-1:0] s1_pwdata,
   output logic [APB_DW-1:0] s1_prdata,
   output logic              s1_pready,
   output logic              s1_pslverr,
   output logic              m_psel,
   output logic              m_penable,
   output logic              m_pwrite,
   output logic [APB_AW-1:0] m_paddr,
   output logic [APB_DW-1:0] m_pwdata,
   output logic [APB_UW-1:0] m_pauser,
   input  logic [APB_DW-1:0] m_prdata,
   input  logic              m_pready,
   input  logic              m_pslverr,
   output logic              timeout_evt
);
   localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);

   arb_state_e        state_q, state_d;
   logic              gnt_q, gnt_d, last_q, last_d, write_q, write_d;
   logic              err_q, err_d, tevt_q, tevt_d, psel_q, psel_d, pen_q, pen_d;
   logic [1:0]        rdy_q, rdy_d, pend;
   logic              pick;
   logic [APB_AW-1:0] addr_q, addr_d;
   logic [APB_DW-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
   logic [APB_UW-1:0] user_q, user_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              unused_penable;

   assign unused_penable = s0_penable ^ s1_penable;

   // last_q only moves on contention, so a lone requester never steals the next turn
   always_comb begin
      pend    = {s1_psel, s0_psel};
      pick    = &pend ? ~last_q : pend[1];
      state_d = state_q;
      gnt_d   = gnt_q;
      last_d  = last_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      write_d = write_q;
      user_d  = user_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      tevt_d  = 1'b0;
      case (state_q)
         IDLE: if (|pend) begin
            state_d = SETUP;
            gnt_d   = pick;
            last_d  = &pend ? pick : last_q;
            addr_d  = pick ? s1_paddr : s0_paddr;
            wdata_d = pick ? s1_pwdata : s0_pwdata;
            write_d = pick ? s1_pwrite : s0_pwrite;
            user_d  = pick ? PORT1_PAUSER : PORT0_PAUSER;
            cnt_d   = '0;
         end
         SETUP: state_d = ACCESS;
         ACCESS: if (m_pready) begin
            state_d = RESP;
            rdata_d = m_prdata;
            err_d   = m_pslverr;
         end else if (cnt_q == CNT_MAX) begin
            state_d = RESP;
            rdata_d = '0;
            err_d   = 1'b1;
            tevt_d  = 1'b1;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
         default: state_d = IDLE;
      endcase
      psel_d = (state_d == SETUP) || (state_d == ACCESS);
      pen_d  = state_d == ACCESS;
      rdy_d  = state_d == RESP ? (gnt_d ? 2'b10 : 2'b01) : 2'b00;
   end

   always_ff @(posedge core_clk) begin
      if (!cptra_rst_b) begin
         state_q <= IDLE;
         gnt_q   <= 1'b0;
         last_q  <= 1'b1;
         addr_q  <= '0;
         wdata_q <= '0;
         write_q <= 1'b0;
         user_q  <= '0;
         cnt_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         tevt_q  <= 1'b0;
         psel_q  <= 1'b0;
         pen_q   <= 1'b0;
         rdy_q   <= 2'b00;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         last_q  <= last_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         write_q <= write_d;
         user_q  <= user_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         tevt_q  <= tevt_d;
         psel_q  <= psel_d;
         pen_q   <= pen_d;
         rdy_q   <= rdy_d;
      end
   end

   assign m_psel      = psel_q;
   assign m_penable   = pen_q;
   assign m_pwrite    = write_q;
   assign m_paddr     = addr_q;
   assign m_pwdata    = wdata_q;
   assign m_pauser    = user_q;
   assign timeout_evt = tevt_q;
   assign s0_pready   = rdy_q[0];
   assign s0_pslverr  = rdy_q[0] & err_q;
   assign s0_prdata   = rdy_q[0] ? rdata_q : '0;
   assign s1_pready   = rdy_q[1];
   assign s1_pslverr  = rdy_q[1] & err_q;
   assign s1_prdata   = rdy_q[1] ? rdata_q : '0;
endmodule

// File: tb/tb_caliptra_apb_arbiter.sv
// tb_caliptra_apb_arbiter: random two-requester traffic against a transaction-level timing model
module tb_caliptra_apb_arbiter;
   localparam int TO = 6;
   localparam logic [31:0] P0U = 32'hFFFF_FFFF;
   localparam logic [31:0] P1U = 32'h0000_0001;

   typedef struct {
      logic [31:0] addr, wdata, rdata;
      logic        write, err;
      int          dly;
   } tx_t;

   logic        core_clk = 1'b0;
   logic        cptra_rst_b = 1'b0;
   logic        s_psel[2] = '{1'b0, 1'b0};
   logic        s_pen[2] = '{1'b0, 1'b0};
   logic        s_pwr[2] = '{1'b0, 1'b0};
   logic [31:0] s_addr[2] = '{32'h0, 32'h0};
   logic [31:0] s_wdata[2] = '{32'h0, 32'h0};
   logic [31:0] s0_prdata, s1_prdata, m_paddr, m_pwdata, m_pauser;
   logic        s0_pready, s0_pslverr, s1_pready, s1_pslverr;
   logic        m_psel, m_penable, m_pwrite, timeout_evt;
   logic [31:0] m_prdata = 32'h0;
   logic        m_pready = 1'b0;
   logic        m_pslverr = 1'b0;

   caliptra_apb_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
      .core_clk(core_clk), .cptra_rst_b(cptra_rst_b),
      .s0_psel(s_psel[0]), .s0_penable(s_pen[0]), .s0_pwrite(s_pwr[0]),
      .s0_paddr(s_addr[0]), .s0_pwdata(s_wdata[0]),
      .s0_prdata(s0_prdata), .s0_pready(s0_pready), .s0_pslverr(s0_pslverr),
      .s1_psel(s_psel[1]), .s1_penable(s_pen[1]), .s1_pwrite(s_pwr[1]),
      .s1_paddr(s_addr[1]), .s1_pwdata(s_wdata[1]),
      .s1_prdata(s1_prdata), .s1_pready(s1_pready), .s1_pslverr(s1_pslverr),
      .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
      .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_pauser(m_pauser),
      .m_prdata(m_prdata), .m_pready(m_pready), .m_pslverr(m_pslverr),
      .timeout_evt(timeout_evt)
   );

   always #5 core_clk = ~core_clk;

   int  total = 0, bad = 0;
   int  edge_n = 0, free_at = 0, m_start = 0, m_resp = 0, m_gnt = 0, quota = 0, lc = 0;
   int  issued[2] = '{0, 0};
   int  idle[2] = '{0, 0};
   bit  req[2] = '{1'b0, 1'b0};
   bit  drop[2] = '{1'b0, 1'b0};
   bit  act = 1'b0, m_to = 1'b0, last = 1'b1;
   bit  psel_e, pen_e, fin;
   logic [31:0] rd_e;
   logic er_e;
   tx_t m_tx, cur[2];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, lc);
      end
   endtask

   function automatic tx_t gen(input int p, input int n);
      tx_t t;
      t.addr  = $urandom;
      t.wdata = $urandom;
      t.rdata = $urandom;
      t.write = 1'($urandom_range(0, 1));
      t.err   = ($urandom_range(0, 3) == 0);
      t.dly   = int'($urandom_range(0, 8));
      if (n == 20) t.dly = 9;
      if (n == 0 && p == 0) begin
         t.addr = 32'h3003_0000; t.wdata = 32'hDEAD_BEEF; t.write = 1'b1; t.dly = 0; t.err = 1'b0;
      end
      if (n == 0 && p == 1) begin
         t.write = 1'b0; t.dly = 5; t.rdata = 32'h1234_5678; t.err = 1'b0;
      end
      return t;
   endfunction

   // model: a grant at edge e completes (RESP) at edge e+2+min(dly,TO-1); arbiter resamples two edges later
   always @(posedge core_clk) begin
      if (!cptra_rst_b) begin
         act = 1'b0; last = 1'b1; free_at = edge_n + 1;
      end else if (edge_n >= free_at && (s_psel[0] || s_psel[1])) begin
         m_gnt = (s_psel[0] && s_psel[1]) ? (last ? 0 : 1) : (s_psel[1] ? 1 : 0);
         if (s_psel[0] && s_psel[1]) last = (m_gnt == 1);
         m_tx    = cur[m_gnt];
         m_to    = m_tx.dly >= TO;
         m_start = edge_n;
         m_resp  = edge_n + 2 + (m_to ? TO - 1 : m_tx.dly);
         free_at = m_resp + 2;
         act     = 1'b1;
      end
      edge_n++;
   end

   always @(negedge core_clk) begin
      lc     = edge_n - 1;
      psel_e = act && lc >= m_start && lc < m_resp;
      pen_e  = act && lc > m_start && lc < m_resp;
      fin    = act && lc == m_resp;
      rd_e   = m_to ? 32'h0 : m_tx.rdata;
      er_e   = m_to ? 1'b1 : m_tx.err;
      chk("m_psel", m_psel, psel_e);
      chk("m_penable", m_penable, pen_e);
      chk("timeout_evt", timeout_evt, fin && m_to);
      chk("s0_pready", s0_pready, fin && m_gnt == 0);
      chk("s1_pready", s1_pready, fin && m_gnt == 1);
      chk("s0_prdata", s0_prdata, (fin && m_gnt == 0) ? rd_e : 32'h0);
      chk("s1_prdata", s1_prdata, (fin && m_gnt == 1) ? rd_e : 32'h0);
      chk("s0_pslverr", s0_pslverr, (fin && m_gnt == 0) ? er_e : 1'b0);
      chk("s1_pslverr", s1_pslverr, (fin && m_gnt == 1) ? er_e : 1'b0);
      if (psel_e) begin
         chk("m_paddr", m_paddr, m_tx.addr);
         chk("m_pwdata", m_pwdata, m_tx.wdata);
         chk("m_pwrite", m_pwrite, m_tx.write);
         chk("m_pauser", m_pauser, m_gnt == 1 ? P1U : P0U);
      end
      for (int p = 0; p < 2; p++) begin
         if (!cptra_rst_b) begin
            req[p] = 1'b0; s_psel[p] = 1'b0; s_pen[p] = 1'b0; idle[p] = 0;
         end else if (req[p]) begin
            s_pen[p] = s_psel[p];
            if (act && m_gnt == p && lc == m_start && drop[p]) begin
               s_psel[p] = 1'b0; s_pen[p] = 1'b0;
            end
            if (fin && m_gnt == p) begin
               req[p] = 1'b0; s_psel[p] = 1'b0; s_pen[p] = 1'b0;
               idle[p] = int'($urandom_range(0, 3));
            end
         end else if (idle[p] > 0) begin
            idle[p]--;
         end else if (issued[p] < quota) begin
            cur[p]     = gen(p, issued[p]);
            issued[p]++;
            req[p]     = 1'b1;
            s_psel[p]  = 1'b1;
            s_pen[p]   = 1'b0;
            s_addr[p]  = cur[p].addr;
            s_wdata[p] = cur[p].wdata;
            s_pwr[p]   = cur[p].write;
            drop[p]    = ($urandom_range(0, 7) == 0);
         end
      end
      m_pready  = pen_e && (lc - m_start - 1 == m_tx.dly);
      m_prdata  = m_pready ? m_tx.rdata : $urandom;
      m_pslverr = m_pready ? m_tx.err : 1'($urandom_range(0, 1));
   end

   task automatic wait_done(input string tag);
      int n = 0;
      while ((req[0] || req[1] || issued[0] < quota || issued[1] < quota) && n < 4000) begin
         @(posedge core_clk);
         n++;
      end
      chk(tag, 32'(n < 4000), 32'h1);
      repeat (5) @(posedge core_clk);
   endtask

   initial begin
      int n;
      repeat (3) @(posedge core_clk);
      #3 cptra_rst_b = 1'b1;
      quota = 20;
      wait_done("random_phase_done");
      quota = 21;
      n = 0;
      while (!m_penable && n < 100) begin
         @(negedge core_clk);
         n++;
      end
      chk("reach_access", 32'(n < 100), 32'h1);
      @(posedge core_clk);
      #3 cptra_rst_b = 1'b0;
      @(posedge core_clk);
      #3 cptra_rst_b = 1'b1;
      repeat (3) @(posedge core_clk);
      quota = 22;
      wait_done("post_reset_done");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
